// File: rtl/jacobi_pivot_selector_if.sv
// rtl/jacobi_pivot_selector_if.sv - pivot selector BRAM/result bus
interface jacobi_pivot_selector_if;
  logic        start;
  logic        ena_cov;
  logic [1:0]  addra_cov;
  logic [31:0] douta_cov;
  logic [1:0]  p;
  logic [1:0]  q;
  logic [7:0]  pivot_mag;
  logic        valid;
  logic        converged;
  logic        busy;

  modport master (
    output start, douta_cov,
    input  ena_cov, addra_cov, p, q, pivot_mag, valid, converged, busy
  );

  modport slave (
    input  start, douta_cov,
    output ena_cov, addra_cov, p, q, pivot_mag, valid, converged, busy
  );
endinterface

// File: rtl/jacobi_pivot_selector.sv
// rtl/jacobi_pivot_selector.sv - largest off-diagonal pivot search over a 4x4 covariance
module jacobi_pivot_selector #(
  parameter int RD_LAT      = 1,
  parameter int CONV_THRESH = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  jacobi_pivot_selector_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, DONE} state_t;

  localparam logic [2:0] LAT3 = 3'(RD_LAT);
  localparam logic [7:0] THR8 = 8'(CONV_THRESH);
  localparam logic [1:0] P_TAB [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  localparam logic [1:0] Q_TAB [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        ena_q;
  logic [1:0]  addr_q;
  logic [7:0]  e01_q, e02_q, e03_q, e12_q, e13_q, e23_q;
  logic [1:0]  p_q, q_q;
  logic [7:0]  mag_q;
  logic        conv_q, valid_q, busy_q;

  logic [7:0]  mags [6];
  logic [7:0]  best_mag_d;
  logic [1:0]  best_p_d, best_q_d;
  logic        cap_en;
  logic [2:0]  cap_row;
  logic        unused_col0;

  // Column 0 is only ever a lower-triangle or diagonal entry, so it is never a candidate.
  assign unused_col0 = ^bus.douta_cov[31:24];

  assign bus.ena_cov   = ena_q;
  assign bus.addra_cov = addr_q;
  assign bus.p         = p_q;
  assign bus.q         = q_q;
  assign bus.pivot_mag = mag_q;
  assign bus.valid     = valid_q;
  assign bus.converged = conv_q;
  assign bus.busy      = busy_q;

  // Absolute value with -128 clamped so the magnitude fits in 7 bits.
  function automatic logic [7:0] mag8(input logic [7:0] x);
    if (x == 8'h80)
      return 8'd127;
    else if (x[7])
      return 8'(~x + 8'd1);
    else
      return x;
  endfunction

  // Row read in scan cycle k arrives RD_LAT cycles later; cnt_q counts from the first READ cycle.
  always_comb begin
    cap_row = cnt_q - LAT3;
    cap_en  = ((state_q == READ) || (state_q == WAIT)) && (cnt_q >= LAT3) && (cap_row <= 3'd2);
  end

  // Strictly-greater scan over the upper triangle so ties keep the earliest candidate.
  always_comb begin
    mags[0] = mag8(e01_q);
    mags[1] = mag8(e02_q);
    mags[2] = mag8(e03_q);
    mags[3] = mag8(e12_q);
    mags[4] = mag8(e13_q);
    mags[5] = mag8(e23_q);
    best_mag_d = mags[0];
    best_p_d   = P_TAB[0];
    best_q_d   = Q_TAB[0];
    for (int i = 1; i < 6; i++) begin
      if (mags[i] > best_mag_d) begin
        best_mag_d = mags[i];
        best_p_d   = P_TAB[i];
        best_q_d   = Q_TAB[i];
      end
    end
  end

  // Scan FSM with registered BRAM controls, row capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ena_q   <= 1'b0;
      addr_q  <= 2'd0;
      e01_q   <= 8'd0;
      e02_q   <= 8'd0;
      e03_q   <= 8'd0;
      e12_q   <= 8'd0;
      e13_q   <= 8'd0;
      e23_q   <= 8'd0;
      p_q     <= 2'd0;
      q_q     <= 2'd1;
      mag_q   <= 8'd0;
      conv_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cap_en) begin
        case (cap_row)
          3'd0: begin
            e01_q <= bus.douta_cov[23:16];
            e02_q <= bus.douta_cov[15:8];
            e03_q <= bus.douta_cov[7:0];
          end
          3'd1: begin
            e12_q <= bus.douta_cov[15:8];
            e13_q <= bus.douta_cov[7:0];
          end
          default: e23_q <= bus.douta_cov[7:0];
        endcase
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= READ;
            cnt_q   <= 3'd0;
            ena_q   <= 1'b1;
            addr_q  <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd2) begin
            ena_q   <= 1'b0;
            addr_q  <= 2'd0;
            state_q <= WAIT;
          end else begin
            addr_q <= addr_q + 2'd1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAT3 + 3'd2)
            state_q <= EVAL;
        end
        EVAL: begin
          p_q     <= best_p_d;
          q_q     <= best_q_d;
          mag_q   <= best_mag_d;
          conv_q  <= (best_mag_d <= THR8);
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_pivot_selector.sv
// tb/tb_jacobi_pivot_selector.sv - scoreboard bench for jacobi_pivot_selector
module tb_jacobi_pivot_selector;

  typedef struct {
    logic [1:0] p;
    logic [1:0] q;
    logic [7:0] mag;
    logic       conv;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   fails;

  logic [31:0] mem [4];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  exp_t exp1 [$];
  exp_t exp3 [$];
  exp_t e1, e3;

  jacobi_pivot_selector_if if1 ();
  jacobi_pivot_selector_if if3 ();

  jacobi_pivot_selector #(.RD_LAT(1), .CONV_THRESH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  jacobi_pivot_selector #(.RD_LAT(3), .CONV_THRESH(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: garbage whenever the port is not enabled.
  always @(posedge clk) begin
    pipe1    <= if1.ena_cov ? mem[if1.addra_cov] : $urandom;
    pipe3[0] <= if3.ena_cov ? mem[if3.addra_cov] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign if1.douta_cov = pipe1;
  assign if3.douta_cov = pipe3[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the RD_LAT=1 instance.
  always @(negedge clk) begin
    if (rst_n && if1.valid) begin
      if (exp1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL u1_unexpected_valid: got valid expected none (cycle %0d)", cyc);
      end else begin
        e1 = exp1.pop_front();
        chk("u1_latency", cyc, e1.cyc);
        chk("u1_p", int'(if1.p), int'(e1.p));
        chk("u1_q", int'(if1.q), int'(e1.q));
        chk("u1_mag", int'(if1.pivot_mag), int'(e1.mag));
        chk("u1_conv", int'(if1.converged), int'(e1.conv));
      end
    end
  end

  // Monitor for the RD_LAT=3 instance.
  always @(negedge clk) begin
    if (rst_n && if3.valid) begin
      if (exp3.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL u3_unexpected_valid: got valid expected none (cycle %0d)", cyc);
      end else begin
        e3 = exp3.pop_front();
        chk("u3_latency", cyc, e3.cyc);
        chk("u3_p", int'(if3.p), int'(e3.p));
        chk("u3_q", int'(if3.q), int'(e3.q));
        chk("u3_mag", int'(if3.pivot_mag), int'(e3.mag));
        chk("u3_conv", int'(if3.converged), int'(e3.conv));
      end
    end
  end

  task automatic load_rows(input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
    mem[0] = r0;
    mem[1] = r1;
    mem[2] = r2;
    mem[3] = r3;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ena"}, int'(if1.ena_cov), 0);
    chk({tag, "_addr"}, int'(if1.addra_cov), 0);
    chk({tag, "_p"}, int'(if1.p), 0);
    chk({tag, "_q"}, int'(if1.q), 1);
    chk({tag, "_mag"}, int'(if1.pivot_mag), 0);
    chk({tag, "_conv"}, int'(if1.converged), 0);
    chk({tag, "_valid"}, int'(if1.valid), 0);
    chk({tag, "_busy"}, int'(if1.busy), 0);
  endtask

  // One scan on the RD_LAT=1 instance; checks the read sequence and result hold.
  task automatic run1(input string tag, input logic [1:0] p, input logic [1:0] q,
                      input logic [7:0] mag, input logic conv);
    exp_t e;
    e.p = p; e.q = q; e.mag = mag; e.conv = conv; e.cyc = cyc + 6;
    exp1.push_back(e);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_ena"}, int'(if1.ena_cov), 1);
      chk({tag, "_addr"}, int'(if1.addra_cov), k);
      chk({tag, "_busy"}, int'(if1.busy), 1);
      @(negedge clk);
    end
    chk({tag, "_ena_off"}, int'(if1.ena_cov), 0);
    chk({tag, "_addr_off"}, int'(if1.addra_cov), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_idle_busy"}, int'(if1.busy), 0);
    chk({tag, "_hold_p"}, int'(if1.p), int'(p));
    chk({tag, "_hold_q"}, int'(if1.q), int'(q));
    chk({tag, "_hold_mag"}, int'(if1.pivot_mag), int'(mag));
  endtask

  initial begin
    exp_t e;
    int   t;
    cyc = 0;
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    if1.start = 1'b0;
    if3.start = 1'b0;
    load_rows(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    chk("por_u3_busy", int'(if3.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_rows(32'h0510F002, 32'h10070304, 32'hF0030920, 32'h7F7F7F7F);
    run1("t_basic", 2'd2, 2'd3, 8'h20, 1'b0);
    load_rows(32'h0010F000, 32'h0, 32'h0, 32'h0);
    run1("t_tie", 2'd0, 2'd1, 8'd16, 1'b0);
    load_rows(32'h0, 32'h00008000, 32'h0, 32'h80808080);
    run1("t_sat", 2'd1, 2'd2, 8'd127, 1'b0);
    load_rows(32'h000000FF, 32'h00000101, 32'h000000FF, 32'h0);
    run1("t_conv1", 2'd0, 2'd3, 8'd1, 1'b1);
    load_rows(32'h7F000000, 32'h00550000, 32'h0000AA00, 32'hFFFFFFFF);
    run1("t_zero", 2'd0, 2'd1, 8'd0, 1'b1);
    load_rows(32'h00050607, 32'h000011B0, 32'h0000004F, 32'h0);
    run1("t_p1q3", 2'd1, 2'd3, 8'd80, 1'b0);

    // Reset during the second READ cycle; the aborted scan must never report.
    load_rows(32'h00640000, 32'h00007F00, 32'h0000007F, 32'h0);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk);
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    load_rows(32'h0010F000, 32'h0, 32'h0, 32'h0);
    run1("t_after_rst", 2'd0, 2'd1, 8'd16, 1'b0);

    // RD_LAT=3: pulse during WAIT is dropped, held start relaunches right after DONE.
    load_rows(32'h0510F002, 32'h10070304, 32'hF0030920, 32'h0);
    e.p = 2'd2; e.q = 2'd3; e.mag = 8'h20; e.conv = 1'b0; e.cyc = cyc + 8;
    exp3.push_back(e);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (3) @(negedge clk);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    @(negedge clk);
    if3.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("u3_idle_gap_busy", int'(if3.busy), 0);
    e.cyc = cyc + 8;
    exp3.push_back(e);
    @(negedge clk);
    if3.start = 1'b0;
    chk("u3_relaunch_busy", int'(if3.busy), 1);

    t = 0;
    while ((exp1.size() != 0 || exp3.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("queues_drained", exp1.size() + exp3.size(), 0);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
